// File: rtl/result_collector.sv
// result_collector: output stage behind the add/multiply/add datapath.
// An issue strobe is delayed by PIPE_LAT cycles so that it lines up with the
// matching {result_2_i, result_i} pair. Each aligned pair is captured into a
// show-ahead FIFO, which is drained over a valid/ready interface.
// Optional feature: define RESULT_ACC_EN to enable a saturating 16-bit
// running sum of all pushed operands on acc_o. Without it, acc_o is 0.
module result_collector #(
  parameter int WIDTH    = 8,
  parameter int PIPE_LAT = 2,
  parameter int DEPTH    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     issue_valid_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         result_i,
  input  logic [WIDTH-1:0]         result_2_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [2*WIDTH-1:0]       m_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o,
  output logic [15:0]              acc_o
);

  localparam int AW = $clog2(DEPTH);
  // The delay line needs at least one bit of storage to be declarable.
  localparam int DW = (PIPE_LAT > 0) ? PIPE_LAT : 1;

  logic              clear;
  logic              cap;
  logic              push;
  logic              pop;
  logic              drop;
  logic              full;
  logic              empty;
  logic [DW-1:0]     dly_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              overflow_q;
  logic [2*WIDTH-1:0] mem [DEPTH];

  // Reset and flush both discard everything; reset simply wins when both are high.
  assign clear = rst_i | flush_i;

  generate
    if (PIPE_LAT == 0) begin : g_no_delay
      // Zero latency: the pair arrives together with its issue strobe.
      assign cap   = issue_valid_i;
      assign dly_q = '0;
    end else begin : g_delay
      // Shift the issue strobe along; the oldest stage marks a valid pair.
      // NOTE: sequential state uses non-blocking (<=) so every register
      // samples the pre-edge values, independent of block ordering.
      always_ff @(posedge clk_i) begin
        if (clear) dly_q <= '0;
        else       dly_q <= (dly_q << 1) | DW'(issue_valid_i);
      end
      assign cap = dly_q[DW-1];
    end
  endgenerate

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = ~empty & m_ready_i;
  // A full FIFO still accepts a pair when the head leaves in the same cycle.
  assign push  = cap & (~full | pop);
  assign drop  = cap & full & ~pop;

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk_i) begin
    if (clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Storage array written on each accepted capture.
  // NOTE: the array has no reset; every entry is written before it can be
  // read, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (push && !clear) mem[wr_ptr_q] <= {result_2_i, result_i};
  end

  // Show-ahead head: data is stable while the head is not popped because a
  // write only hits rd_ptr when the FIFO is empty or popped in that cycle.
  assign m_data_o   = mem[rd_ptr_q];
  assign m_valid_o  = ~empty;
  assign count_o    = count_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign overflow_o = overflow_q;

`ifdef RESULT_ACC_EN
  logic [15:0] acc_q;
  logic [16:0] acc_sum;

  // One spare bit catches the carry that signals saturation.
  // NOTE: combinational logic uses blocking (=) and assigns every output on
  // every path so no latch is inferred.
  always_comb begin
    acc_sum = {1'b0, acc_q} + 17'(result_i) + 17'(result_2_i);
  end

  // Saturating accumulator; dropped pairs never reach it.
  always_ff @(posedge clk_i) begin
    if (clear)     acc_q <= '0;
    else if (push) acc_q <= acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
  end

  assign acc_o = acc_q;
`else
  assign acc_o = 16'h0000;
`endif

endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: randomized and directed stimulus for result_collector,
// checked against a queue-based reference model of the collector.
module tb_result_collector;

  localparam int WIDTH    = 8;
  localparam int PIPE_LAT = 2;
  localparam int DEPTH    = 8;

  logic                   clk = 1'b0;
  logic                   rst_i = 1'b1;
  logic                   issue_valid_i = 1'b0;
  logic                   flush_i = 1'b0;
  logic [WIDTH-1:0]       result_i = '0;
  logic [WIDTH-1:0]       result_2_i = '0;
  logic                   m_valid_o;
  logic                   m_ready_i = 1'b0;
  logic [2*WIDTH-1:0]     m_data_o;
  logic [$clog2(DEPTH):0] count_o;
  logic                   full_o;
  logic                   empty_o;
  logic                   overflow_o;
  logic [15:0]            acc_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state.
  logic [15:0] exp_q[$];
  bit          infl[$];
  bit          exp_ovf;
  int          exp_acc;

  result_collector #(.WIDTH(WIDTH), .PIPE_LAT(PIPE_LAT), .DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .issue_valid_i(issue_valid_i),
    .flush_i      (flush_i),
    .result_i     (result_i),
    .result_2_i   (result_2_i),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .count_o      (count_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .overflow_o   (overflow_o),
    .acc_o        (acc_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    infl.delete();
    repeat (PIPE_LAT) infl.push_back(1'b0);
    exp_ovf = 1'b0;
    exp_acc = 0;
  endtask

  // Next-state of the model for one clock edge, given this cycle's inputs.
  task automatic model_edge(input bit iv, input bit rdy, input bit fl, input bit rs,
                            input logic [7:0] a, input logic [7:0] b);
    bit cap;
    bit was_full;
    bit pop;
    if (rs || fl) begin
      model_clear();
      return;
    end
    cap      = (PIPE_LAT == 0) ? iv : infl[0];
    was_full = (exp_q.size() == DEPTH);
    pop      = rdy && (exp_q.size() > 0);
    if (pop) void'(exp_q.pop_front());
    if (cap) begin
      if (!was_full || pop) begin
        exp_q.push_back({b, a});
`ifdef RESULT_ACC_EN
        exp_acc = exp_acc + int'(a) + int'(b);
        if (exp_acc > 65535) exp_acc = 65535;
`endif
      end else begin
        exp_ovf = 1'b1;
      end
    end
    if (PIPE_LAT > 0) begin
      void'(infl.pop_front());
      infl.push_back(iv);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(m_valid_o), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) check({tag, ".data"}, 32'(m_data_o), 32'(exp_q[0]));
    check({tag, ".count"}, 32'(count_o), 32'(exp_q.size()));
    check({tag, ".full"},  32'(full_o),  32'(exp_q.size() == DEPTH));
    check({tag, ".empty"}, 32'(empty_o), 32'(exp_q.size() == 0));
    check({tag, ".ovf"},   32'(overflow_o), 32'(exp_ovf));
    check({tag, ".acc"},   32'(acc_o), 32'(exp_acc));
  endtask

  // Drive one cycle of inputs, advance one clock, then compare at the falling edge.
  task automatic step(input string tag, input bit iv, input bit rdy, input bit fl,
                      input bit rs, input logic [7:0] a, input logic [7:0] b);
    issue_valid_i = iv;
    m_ready_i     = rdy;
    flush_i       = fl;
    rst_i         = rs;
    result_i      = a;
    result_2_i    = b;
    model_edge(iv, rdy, fl, rs, a, b);
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    model_clear();
    @(negedge clk);

    // Reset values.
    step("rst", 0, 0, 0, 1, 8'h00, 8'h00);
    step("rst", 0, 0, 0, 1, 8'h00, 8'h00);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_count", 32'(count_o), 32'd0);

    // Single pair: issue at cycle 0, pair on the bus at cycle 2, visible at cycle 3.
    step("single", 1, 1, 0, 0, 8'h00, 8'h00);
    step("single", 0, 1, 0, 0, 8'h00, 8'h00);
    step("single", 0, 1, 0, 0, 8'h12, 8'h34);
    check("single_valid", 32'(m_valid_o), 32'd1);
    check("single_data", 32'(m_data_o), 32'h3412);
    step("single", 0, 1, 0, 0, 8'h00, 8'h00);
    check("single_empty", 32'(empty_o), 32'd1);

    // Fill with results 1..8 while the consumer stalls.
    for (int i = 0; i < 8 + PIPE_LAT; i++)
      step("fill", i < 8, 0, 0, 0, (i >= PIPE_LAT) ? 8'(i - PIPE_LAT + 1) : 8'h00, 8'h00);
    check("fill_full", 32'(full_o), 32'd1);
    check("fill_count", 32'(count_o), 32'd8);
    check("fill_ovf", 32'(overflow_o), 32'd0);
    // Ninth capture is dropped.
    step("drop", 1, 0, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < PIPE_LAT; i++) step("drop", 0, 0, 0, 0, 8'h09, 8'h00);
    step("drop", 0, 0, 0, 0, 8'h00, 8'h00);
    check("drop_ovf", 32'(overflow_o), 32'd1);
    check("drop_count", 32'(count_o), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", 32'(m_data_o[7:0]), 32'(i));
      step("drain", 0, 1, 0, 0, 8'h00, 8'h00);
    end
    check("drain_ovf_sticky", 32'(overflow_o), 32'd1);
    step("flush0", 0, 0, 1, 0, 8'h00, 8'h00);

    // Full FIFO: pop and capture in the same cycle.
    for (int i = 0; i < 8 + PIPE_LAT; i++)
      step("fill2", i < 8, 0, 0, 0, 8'(8'h20 + i), 8'h00);
    step("pushpop", 1, 0, 0, 0, 8'h00, 8'h00);
    for (int i = 1; i < PIPE_LAT; i++) step("pushpop", 0, 0, 0, 0, 8'h00, 8'h00);
    step("pushpop", 0, 1, 0, 0, 8'hAA, 8'h55);
    check("pushpop_count", 32'(count_o), 32'd8);
    check("pushpop_ovf", 32'(overflow_o), 32'd0);
    for (int i = 0; i < 7; i++) step("pushpop_drain", 0, 1, 0, 0, 8'h00, 8'h00);
    check("pushpop_last", 32'(m_data_o), 32'h55AA);
    step("pushpop_drain", 0, 1, 0, 0, 8'h00, 8'h00);

    // Flush with three entries buffered and one pair in flight.
    for (int i = 0; i < 3 + PIPE_LAT; i++) step("pre_flush", i < 3, 0, 0, 0, 8'h31, 8'h13);
    step("pre_flush", 1, 0, 0, 0, 8'h00, 8'h00);
    step("flush", 0, 0, 1, 0, 8'hEE, 8'hEE);
    check("flush_empty", 32'(empty_o), 32'd1);
    check("flush_count", 32'(count_o), 32'd0);
    check("flush_ovf", 32'(overflow_o), 32'd0);
    for (int i = 0; i < 4; i++) step("post_flush", 0, 1, 0, 0, 8'hEE, 8'hEE);

    // 129 captures of (FF, FF): accumulator saturates when enabled, stays 0 otherwise.
    for (int i = 0; i < 129 + PIPE_LAT; i++) step("acc", i < 129, 1, 0, 0, 8'hFF, 8'hFF);
`ifdef RESULT_ACC_EN
    check("acc_sat", 32'(acc_o), 32'h0000_FFFF);
`else
    check("acc_off", 32'(acc_o), 32'h0);
`endif
    step("acc", 0, 1, 0, 0, 8'h00, 8'h00);

    // Reset mid-transfer with a pair visible and another in flight.
    step("mid_rst", 1, 0, 0, 0, 8'h00, 8'h00);
    step("mid_rst", 1, 0, 0, 0, 8'h00, 8'h00);
    step("mid_rst", 0, 0, 0, 0, 8'h41, 8'h14);
    check("mid_rst_valid_before", 32'(m_valid_o), 32'd1);
    step("mid_rst", 0, 0, 0, 1, 8'h42, 8'h24);
    check("mid_rst_valid", 32'(m_valid_o), 32'd0);
    check("mid_rst_empty", 32'(empty_o), 32'd1);
    check("mid_rst_acc", 32'(acc_o), 32'd0);
    for (int i = 0; i < 4; i++) step("post_rst", 0, 1, 0, 0, 8'h77, 8'h77);

    // Randomized traffic, including occasional flushes and resets.
    for (int i = 0; i < 2000; i++)
      step("rand",
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 5,
           $urandom_range(0, 63) == 0,
           $urandom_range(0, 199) == 0,
           8'($urandom), 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
